mxint_quantizer: RTL and testbench

- Converts a block of signed fixed-point values into one MXINT block: a shared exponent plus per-element signed mantissas.
- It is the producer end of the MXINT stream that mxint_linear, mxint_dot_product and mxint_cast consume.
- It sits between fixed-point datapaths and the MXINT operators.
- Two-stage stallable pipeline with valid/ready on both sides.

---
 rtl/mxint_pkg.sv | 35 +++
 rtl/mxint_quant_lod.sv | 22 ++
 rtl/mxint_quantizer.sv | 135 +++++++++++++
 tb/tb_mxint_quantizer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// Shared helpers for the MXINT producer/consumer blocks: exponent bias,
// shift-width sizing and a generic leading-one detector.
package mxint_pkg;

  localparam int LOD_MAX_W = 64;
  localparam int LOD_IDX_W = 7;

  typedef struct packed {
    logic [LOD_IDX_W-1:0] idx;
    logic                 zero;
  } lod_t;

  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Bits needed to hold values 0..n, never less than one.
  function automatic int shift_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic lod_t lod(input logic [LOD_MAX_W-1:0] vec);
    lod_t r;
    r.idx  = '0;
    r.zero = 1'b1;
    for (int i = 0; i < LOD_MAX_W; i++) begin
      if (vec[i]) begin
        r.idx  = LOD_IDX_W'(i);
        r.zero = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mxint_quant_lod.sv
// Leading-one detector over the OR-reduced magnitude vector of a block.
module mxint_quant_lod
  import mxint_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  lod_t res;

  always_comb begin
    res = lod(LOD_MAX_W'(vec));
  end

  assign idx  = IDX_W'(res.idx);
  assign zero = res.zero;

endmodule

// File: rtl/mxint_quantizer.sv
// Fixed-point block to MXINT (shared exponent + signed mantissas) converter,
// two-stage stallable pipeline with valid/ready on both sides.
module mxint_quantizer
  import mxint_pkg::*;
#(
  parameter int IN_WIDTH      = 16,
  parameter int IN_FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]         data_in,
  input  logic                                        data_in_valid,
  output logic                                        data_in_ready,
  output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]    mdata_out,
  output logic [OUT_EXP_WIDTH-1:0]                    edata_out,
  output logic                                        data_out_valid,
  input  logic                                        data_out_ready
);

  localparam int BIAS    = exp_bias(OUT_EXP_WIDTH);
  localparam int EMAX    = (1 << OUT_EXP_WIDTH) - 1;
  localparam int IDX_W   = shift_width(IN_WIDTH - 1);
  localparam int PEW     = shift_width(EMAX + IN_FRAC_WIDTH + BIAS + OUT_MAN_WIDTH) + 1;
  localparam int SW      = IN_WIDTH + OUT_MAN_WIDTH + 1;
  localparam int MAN_MAX = (1 << (OUT_MAN_WIDTH - 1)) - 1;
  localparam int MAN_MIN = -(1 << (OUT_MAN_WIDTH - 1));

  logic                                     s1_valid;
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]      s1_data;
  logic [OUT_EXP_WIDTH-1:0]                 s1_exp;
  logic signed [PEW-1:0]                    s1_peff;
  logic                                     s1_zero;
  logic                                     s2_valid;
  logic                                     s1_adv;

  logic [IN_WIDTH-1:0]                      mag_or;
  logic [IDX_W-1:0]                         lod_idx;
  logic                                     all_zero;
  int                                       e_b;
  int                                       e_cl;
  int                                       p_eff;

  logic signed [PEW-1:0]                    shift_s;
  logic [PEW-1:0]                           sh_amt;
  logic signed [SW-1:0]                     ext;
  logic signed [SW-1:0]                     shd;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] man;

  assign s1_adv         = !s2_valid || data_out_ready;
  assign data_in_ready  = !s1_valid || s1_adv;
  assign data_out_valid = s2_valid;

  // OR of magnitudes has the same leading one as the largest magnitude.
  always_comb begin
    mag_or = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      mag_or |= data_in[i][IN_WIDTH-1] ? -data_in[i] : data_in[i];
    end
  end

  mxint_quant_lod #(
    .WIDTH (IN_WIDTH),
    .IDX_W (IDX_W)
  ) u_lod (
    .vec  (mag_or),
    .idx  (lod_idx),
    .zero (all_zero)
  );

  always_comb begin
    e_b   = int'(lod_idx) - IN_FRAC_WIDTH + BIAS;
    e_cl  = (e_b < 0) ? 0 : ((e_b > EMAX) ? EMAX : e_b);
    p_eff = e_cl - BIAS + IN_FRAC_WIDTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
      s1_peff  <= '0;
      s1_zero  <= 1'b1;
    end else if (data_in_ready) begin
      s1_valid <= data_in_valid;
      if (data_in_valid) begin
        s1_data <= data_in;
        s1_exp  <= OUT_EXP_WIDTH'(e_cl);
        s1_peff <= PEW'(p_eff);
        s1_zero <= all_zero;
      end
    end
  end

  // Align every element to the block exponent; only an upper exponent clamp
  // can push a mantissa outside the signed M-bit range.
  always_comb begin
    shift_s = s1_peff - PEW'(OUT_MAN_WIDTH - 2);
    sh_amt  = shift_s[PEW-1] ? $unsigned(-shift_s) : $unsigned(shift_s);
    man     = '0;
    ext     = '0;
    shd     = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      ext = SW'($signed(s1_data[i]));
      shd = shift_s[PEW-1] ? (ext <<< sh_amt) : (ext >>> sh_amt);
      if (shd > SW'(MAN_MAX)) begin
        man[i] = OUT_MAN_WIDTH'(MAN_MAX);
      end else if (shd < SW'(MAN_MIN)) begin
        man[i] = OUT_MAN_WIDTH'(MAN_MIN);
      end else begin
        man[i] = shd[OUT_MAN_WIDTH-1:0];
      end
    end
    if (s1_zero) begin
      man = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      mdata_out <= '0;
      edata_out <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        mdata_out <= man;
        edata_out <= s1_zero ? '0 : s1_exp;
      end
    end
  end

endmodule

// File: tb/tb_mxint_quantizer.sv
// Bench for mxint_quantizer: directed vectors, randomized streams against a
// real-arithmetic reference model, backpressure and reset-mid-stall.
module tb_mxint_quantizer;

  localparam int W = 16;
  localparam int F = 8;
  localparam int N = 4;
  localparam int M = 8;

  typedef logic [N-1:0][W-1:0] blk_t;
  typedef logic [N-1:0][M-1:0] man_t;

  typedef struct {
    string name;
    bit    use_b;
    blk_t  x;
    int    e;
    man_t  m;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blk_t       din_a, din_b;
  logic       vin_a, vin_b, rin_a, rin_b;
  man_t       m_a, m_b;
  logic [3:0] e_a;
  logic [2:0] e_b;
  logic       vout_a, vout_b, rout_a, rout_b;

  int n_cmp = 0;
  int n_err = 0;

  mxint_quantizer #(
    .IN_WIDTH(W), .IN_FRAC_WIDTH(F), .BLOCK_SIZE(N), .OUT_MAN_WIDTH(M), .OUT_EXP_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .data_in(din_a), .data_in_valid(vin_a), .data_in_ready(rin_a),
    .mdata_out(m_a), .edata_out(e_a),
    .data_out_valid(vout_a), .data_out_ready(rout_a)
  );

  mxint_quantizer #(
    .IN_WIDTH(W), .IN_FRAC_WIDTH(F), .BLOCK_SIZE(N), .OUT_MAN_WIDTH(M), .OUT_EXP_WIDTH(3)
  ) dut_b (
    .clk(clk), .rst(rst),
    .data_in(din_b), .data_in_valid(vin_b), .data_in_ready(rin_b),
    .mdata_out(m_b), .edata_out(e_b),
    .data_out_valid(vout_b), .data_out_ready(rout_b)
  );

  function automatic blk_t mk(input int a, input int b, input int c, input int d);
    blk_t r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
    return r;
  endfunction

  function automatic man_t mm(input int a, input int b, input int c, input int d);
    man_t r;
    r[0] = M'(a); r[1] = M'(b); r[2] = M'(c); r[3] = M'(d);
    return r;
  endfunction

  function automatic blk_t rand_blk();
    blk_t r;
    for (int i = 0; i < N; i++) begin
      r[i] = $signed(16'($urandom)) >>> $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) r[i] = '0;
    end
    return r;
  endfunction

  // Reference: real value = x/2^F, pick exponent from the largest magnitude,
  // mantissa = floor(x / 2^s) with s = exponent alignment, then saturate.
  function automatic void model(input blk_t x, input int ew, output int e, output man_t m);
    int  bias, emax, maxabs, a, p, eb, s, v;
    real r;
    bias   = (1 << (ew - 1)) - 1;
    emax   = (1 << ew) - 1;
    maxabs = 0;
    m      = '0;
    e      = 0;
    for (int i = 0; i < N; i++) begin
      a = $signed(x[i]);
      if (a < 0) a = -a;
      if (a > maxabs) maxabs = a;
    end
    if (maxabs == 0) return;
    p = 0;
    while ((2 ** (p + 1)) <= maxabs) p++;
    eb = p - F + bias;
    if (eb < 0) eb = 0;
    if (eb > emax) eb = emax;
    e = eb;
    s = (eb - bias + F) - (M - 2);
    for (int i = 0; i < N; i++) begin
      r = $floor(real'($signed(x[i])) / (2.0 ** real'(s)));
      if (r > 127.0)       v = 127;
      else if (r < -128.0) v = -128;
      else                 v = int'(r);
      m[i] = M'(v);
    end
  endfunction

  // Sends one block into an idle pipeline; returns accept flag, valid one and
  // two cycles after the accept edge, and the output block.
  task automatic run_block(input bit use_b, input blk_t x, output logic acc,
                           output logic v1, output logic v2, output int e, output man_t m);
    @(negedge clk);
    if (use_b) begin din_b = x; vin_b = 1'b1; rout_b = 1'b1; end
    else       begin din_a = x; vin_a = 1'b1; rout_a = 1'b1; end
    #1;
    acc = use_b ? rin_b : rin_a;
    @(posedge clk);
    @(negedge clk);
    vin_a = 1'b0;
    vin_b = 1'b0;
    v1 = use_b ? vout_b : vout_a;
    @(posedge clk);
    @(negedge clk);
    v2 = use_b ? vout_b : vout_a;
    e  = use_b ? int'(e_b) : int'(e_a);
    m  = use_b ? m_b : m_a;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (vout_a !== 1'b0 || vout_b !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got a=%b b=%b, expected 0", vout_a, vout_b);
    end
    n_cmp++;
    if (m_a !== '0 || e_a !== '0 || m_b !== '0 || e_b !== '0) begin
      n_err++; $display("FAIL reset_data: got m_a=%h e_a=%0d m_b=%h e_b=%0d, expected 0", m_a, e_a, m_b, e_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rin_a !== 1'b1 || rin_b !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got a=%b b=%b, expected 1", rin_a, rin_b);
    end
  endtask

  task automatic test_directed();
    vec_t tab[7];
    logic acc, v1, v2;
    int   e;
    man_t m;
    tab[0] = '{"normal",      1'b0, mk(256, 128, -64, 0),      7,  mm(64, 32, -16, 0)};
    tab[1] = '{"floor_neg",   1'b0, mk(256, -1, 0, 0),         7,  mm(64, -1, 0, 0)};
    tab[2] = '{"small",       1'b0, mk(3, 0, 0, 0),            0,  mm(96, 0, 0, 0)};
    tab[3] = '{"lower_clamp", 1'b0, mk(1, 0, 0, 0),            0,  mm(32, 0, 0, 0)};
    tab[4] = '{"upper_sat",   1'b1, mk(16384, -32768, 64, 0),  7,  mm(127, -128, 1, 0)};
    tab[5] = '{"zero_block",  1'b0, mk(0, 0, 0, 0),            0,  mm(0, 0, 0, 0)};
    tab[6] = '{"most_neg",    1'b0, mk(-32768, 0, 0, 0),       14, mm(-64, 0, 0, 0)};
    foreach (tab[k]) begin
      run_block(tab[k].use_b, tab[k].x, acc, v1, v2, e, m);
      n_cmp++;
      if (acc !== 1'b1 || v1 !== 1'b0 || v2 !== 1'b1) begin
        n_err++;
        $display("FAIL %s_timing: got ready=%b v1=%b v2=%b, expected 1 0 1", tab[k].name, acc, v1, v2);
      end
      n_cmp++;
      if (e !== tab[k].e || m !== tab[k].m) begin
        n_err++;
        $display("FAIL %s_data: got e=%0d m=%h, expected e=%0d m=%h", tab[k].name, e, m, tab[k].e, tab[k].m);
      end
    end
  endtask

  task automatic test_stream(input string name, input bit use_b, input int nblk, input bit rand_ready);
    blk_t q_x[$];
    blk_t cur, fx;
    man_t om, hm, em;
    int   sent, got, occ, cyc, oe, he, ee, ew;
    logic ov, ir, orr, fire_in, fire_out, held;
    sent = 0; got = 0; occ = 0; cyc = 0; held = 1'b0; he = 0; hm = '0;
    ew  = use_b ? 3 : 4;
    cur = rand_blk();
    while (got < nblk && cyc < 2000) begin
      @(negedge clk);
      orr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (use_b) begin din_b = cur; vin_b = (sent < nblk); rout_b = orr; end
      else       begin din_a = cur; vin_a = (sent < nblk); rout_a = orr; end
      #1;
      ir = use_b ? rin_b : rin_a;
      ov = use_b ? vout_b : vout_a;
      om = use_b ? m_b : m_a;
      oe = use_b ? int'(e_b) : int'(e_a);
      n_cmp++;
      if (ir !== !(occ == 2 && !orr)) begin
        n_err++;
        $display("FAIL %s_in_ready: got %b, expected %b (occupancy %0d, out_ready %b)", name, ir, !(occ == 2 && !orr), occ, orr);
      end
      if (held) begin
        n_cmp++;
        if (ov !== 1'b1 || om !== hm || oe !== he) begin
          n_err++;
          $display("FAIL %s_hold: got v=%b e=%0d m=%h, expected v=1 e=%0d m=%h", name, ov, oe, om, he, hm);
        end
      end
      fire_out = ov && orr;
      if (fire_out) begin
        n_cmp++;
        if (q_x.size() == 0) begin
          n_err++;
          $display("FAIL %s_extra: got unexpected block e=%0d m=%h, expected none", name, oe, om);
        end else begin
          fx = q_x.pop_front();
          model(fx, ew, ee, em);
          if (oe !== ee || om !== em) begin
            n_err++;
            $display("FAIL %s_data: in=%h got e=%0d m=%h, expected e=%0d m=%h", name, fx, oe, om, ee, em);
          end
        end
        got++;
      end
      held    = ov && !orr;
      hm      = om;
      he      = oe;
      fire_in = (sent < nblk) && ir;
      @(posedge clk);
      if (fire_in) begin
        q_x.push_back(cur);
        sent++;
        cur = rand_blk();
      end
      occ = occ + int'(fire_in) - int'(fire_out);
      cyc++;
    end
    @(negedge clk);
    vin_a = 1'b0;
    vin_b = 1'b0;
    n_cmp++;
    if (got != nblk || sent != nblk || q_x.size() != 0) begin
      n_err++;
      $display("FAIL %s_count: got sent=%0d delivered=%0d pending=%0d, expected %0d/%0d/0", name, sent, got, q_x.size(), nblk, nblk);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic acc, v1, v2;
    int   e;
    man_t m;
    @(negedge clk);
    rout_a = 1'b0; din_a = mk(100, 0, 0, 0); vin_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_a = mk(200, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    vin_a = 1'b0;
    #1;
    n_cmp++;
    if (rin_a !== 1'b0 || vout_a !== 1'b1) begin
      n_err++; $display("FAIL stall_full: got in_ready=%b out_valid=%b, expected 0 1", rin_a, vout_a);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (vout_a !== 1'b0 || e_a !== '0 || m_a !== '0 || rin_a !== 1'b1) begin
      n_err++;
      $display("FAIL stall_reset: got v=%b e=%0d m=%h ready=%b, expected 0 0 0 1", vout_a, e_a, m_a, rin_a);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rout_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vout_a !== 1'b0) begin
      n_err++; $display("FAIL stall_discard: got out_valid=%b, expected 0", vout_a);
    end
    run_block(1'b0, mk(256, 128, -64, 0), acc, v1, v2, e, m);
    n_cmp++;
    if (acc !== 1'b1 || v2 !== 1'b1 || e !== 7 || m !== mm(64, 32, -16, 0)) begin
      n_err++;
      $display("FAIL stall_recover: got ready=%b v=%b e=%0d m=%h, expected 1 1 7 %h", acc, v2, e, m, mm(64, 32, -16, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    vin_a = 1'b0; vin_b = 1'b0;
    rout_a = 1'b0; rout_b = 1'b0;
    din_a = '0; din_b = '0;
    test_reset();
    test_directed();
    test_stream("random_a", 1'b0, 40, 1'b0);
    test_stream("random_b", 1'b1, 30, 1'b1);
    test_stream("back_to_back", 1'b0, 6, 1'b1);
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
